// File: rtl/spi_txn_arbiter_if.sv
// Requester handshake and SPI-master command signals of spi_txn_arbiter.
// The slave modport is the arbiter. The master modport is the environment (requesters plus the SPI master).
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 12
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic                  err;
  logic                  busy;
  logic                  spi_newd;
  logic [DW-1:0]         spi_din;
  logic                  spi_cs;

  modport slave (
    input  req, req_data, spi_cs,
    output gnt, done, err, busy, spi_newd, spi_din
  );

  modport master (
    output req, req_data, spi_cs,
    input  gnt, done, err, busy, spi_newd, spi_din
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort ISSUE/XFER after TIMEOUT cycles.
module spi_txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DW         = 12,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input logic              clk,
  input logic              rst,
  spi_txn_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = 4;

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES > 15 || TIMEOUT < 1)
  begin : g_param_check
    $error("spi_txn_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;

  state_t             state, state_nx;
  logic               cs_meta, cs_s;
  logic [IW-1:0]      last, last_nx, sel, cand;
  logic               sel_valid;
  logic [GW-1:0]      gap_cnt, gap_nx;
  logic [NUM_REQ-1:0] gnt_q, gnt_nx, done_q, done_nx;
  logic               newd_q, newd_nx, busy_q, busy_nx;
  logic [DW-1:0]      din_q, din_nx, din_pick;
  logic               timeout_hit;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt, wd_nx;
  logic          err_q, err_nx;
  assign timeout_hit = (wd_cnt == WW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
    end else begin
      cs_meta <= bus.spi_cs;
      cs_s    <= cs_meta;
    end
  end

  // Rotating priority: first set request at or above last+1, wrapping.
  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sel       = last;
    sel_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel       = cand;
      end
    end
  end

  always_comb begin
    din_pick = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) din_pick = bus.req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    gap_nx   = gap_cnt;
    gnt_nx   = '0;
    done_nx  = '0;
    newd_nx  = newd_q;
    busy_nx  = busy_q;
    din_nx   = din_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_nx   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sel_valid) begin
          gnt_nx[sel] = 1'b1;
          din_nx      = din_pick;
          newd_nx     = 1'b1;
          busy_nx     = 1'b1;
          last_nx     = sel;
          state_nx    = ISSUE;
        end
      end
      // The master samples newd on its slow sclk, so it stays high until cs is seen low.
      ISSUE: begin
        if (!cs_s) begin
          newd_nx  = 1'b0;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (cs_s) begin
          done_nx[last] = 1'b1;
          gap_nx        = GW'(GAP_CYCLES);
          state_nx      = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          gap_nx = gap_cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Watchdog abort applies only while still waiting on the master.
    if (timeout_hit && (state == ISSUE || state == XFER) && state_nx == state) begin
      newd_nx  = 1'b0;
      gap_nx   = GW'(GAP_CYCLES);
      state_nx = GAP;
`ifdef SPI_ARB_TIMEOUT_EN
      err_nx   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last    <= IW'(NUM_REQ - 1);
      gap_cnt <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      newd_q  <= 1'b0;
      busy_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      gap_cnt <= gap_nx;
      gnt_q   <= gnt_nx;
      done_q  <= done_nx;
      newd_q  <= newd_nx;
      busy_q  <= busy_nx;
      din_q   <= din_nx;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Counts cycles spent in ISSUE/XFER; any state change restarts it.
  always_comb begin
    wd_nx = '0;
    if (state_nx == state && (state == ISSUE || state == XFER)) wd_nx = wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= wd_nx;
      err_q  <= err_nx;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.spi_newd = newd_q;
  assign bus.spi_din  = din_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: stimulus queues expected grants/completions, monitors compare.
module tb_spi_txn_arbiter;
  localparam int NR = 4;
  localparam int DW = 12;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 4096;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_txn_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();
  spi_txn_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus0 ();

  spi_txn_arbiter #(.NUM_REQ(NR), .DW(DW), .GAP_CYCLES(2), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  spi_txn_arbiter #(.NUM_REQ(NR), .DW(DW), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_gap0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } gnt_t;

  gnt_t exp_gnt[$];
  int   exp_done[$];

  int n_gnt = 0, n_done = 0, n_err = 0, n_gnt0 = 0, n_done0 = 0;
  int gnt_cyc, done_cyc, err_cyc, newd_fall_cyc, busy_fall_cyc, gnt0_cyc, done0_cyc;

  initial begin : monitor
    gnt_t e;
    int   d;
    logic newd_prev = 1'b0;
    logic busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        n_gnt++;
        gnt_cyc = cyc;
        if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(bus.gnt), 0);
        else begin
          e = exp_gnt.pop_front();
          check("gnt_index", 32'(bus.gnt), 32'(1) << e.idx);
          check("gnt_din", 32'(bus.spi_din), 32'(e.data));
          check("gnt_newd_busy", {bus.spi_newd, bus.busy}, 2'b11);
        end
      end
      if (bus.done != '0) begin
        n_done++;
        done_cyc = cyc;
        if (exp_done.size() == 0) check("done_unexpected", 32'(bus.done), 0);
        else begin
          d = exp_done.pop_front();
          check("done_index", 32'(bus.done), 32'(1) << d);
        end
      end
      if (bus.err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (newd_prev && !bus.spi_newd) newd_fall_cyc = cyc;
      if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
      newd_prev = bus.spi_newd;
      busy_prev = bus.busy;
    end
  end

  initial begin : monitor0
    forever begin
      @(negedge clk);
      if (bus0.gnt != '0) begin
        n_gnt0++;
        gnt0_cyc = cyc;
        check("gap0_gnt", 32'(bus0.gnt), 32'h2);
        check("gap0_din", 32'(bus0.spi_din), 32'h0F1);
      end
      if (bus0.done != '0) begin
        n_done0++;
        done0_cyc = cyc;
        check("gap0_done", 32'(bus0.done), 32'h2);
      end
    end
  end

  // SPI master model: cs falls cs_fall_dly cycles after newd is seen, stays low cs_len cycles.
  int cs_fall_dly = 5;
  int cs_len      = 20;
  bit cs_en       = 1'b1;
  int cs_fall_cyc, cs_rise_cyc;

  initial begin : spi_model
    bus.spi_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && cs_en && bus.spi_newd) begin
        repeat (cs_fall_dly) @(negedge clk);
        bus.spi_cs  = 1'b0;
        cs_fall_cyc = cyc;
        for (int i = 0; i < cs_len && rst; i++) @(negedge clk);
        bus.spi_cs  = 1'b1;
        cs_rise_cyc = cyc;
      end
    end
  end

  initial begin : spi_model0
    bus0.spi_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && bus0.spi_newd) begin
        repeat (3) @(negedge clk);
        bus0.spi_cs = 1'b0;
        repeat (10) @(negedge clk);
        bus0.spi_cs = 1'b1;
      end
    end
  end

  function automatic int count_of(input int which);
    case (which)
      0:       return n_gnt;
      1:       return n_done;
      2:       return n_err;
      3:       return n_gnt0;
      default: return n_done0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, input string name);
    int n = 0;
    while (count_of(which) < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(count_of(which) >= target), 1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin : stim
    int base, dbase, req_cyc, gbase;
    bus.req       = '0;
    bus.req_data  = '0;
    bus0.req      = '0;
    bus0.req_data = '0;
    #1 rst = 1'b0;
    tick(3);
    check("rst_gnt",  32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err",  32'(bus.err), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_newd", 32'(bus.spi_newd), 0);
    check("rst_din",  32'(bus.spi_din), 0);
    rst = 1'b1;
    tick(3);

    // Round-robin with all four requests held.
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = 12'h100 + 12'(i);
    foreach (exp_gnt[i]) ;
    exp_gnt.push_back('{0, 12'h100}); exp_gnt.push_back('{1, 12'h101});
    exp_gnt.push_back('{2, 12'h102}); exp_gnt.push_back('{3, 12'h103});
    exp_gnt.push_back('{0, 12'h100});
    for (int i = 0; i < 5; i++) exp_done.push_back(i % NR);
    base  = n_gnt;
    dbase = n_done;
    bus.req = 4'b1111;
    wait_for(0, base + 5, 400, "rr_grants");
    bus.req = '0;
    check("rr_gap_spacing", 32'(gnt_cyc - done_cyc), 4);
    wait_for(1, dbase + 5, 200, "rr_dones");
    tick(10);

    // Single request with a long frame.
    cs_fall_dly = 40;
    cs_len      = 500;
    bus.req_data[0 +: DW] = 12'hA5C;
    exp_gnt.push_back('{0, 12'hA5C});
    exp_done.push_back(0);
    base    = n_gnt;
    dbase   = n_done;
    req_cyc = cyc;
    bus.req = 4'b0001;
    wait_for(0, base + 1, 10, "single_gnt_seen");
    bus.req = '0;
    check("single_gnt_latency", 32'(gnt_cyc - req_cyc), 1);
    wait_for(1, dbase + 1, 700, "single_done_seen");
    check("single_newd_fall", 32'(newd_fall_cyc - cs_fall_cyc), 3);
    check("single_done_latency", 32'(done_cyc - cs_rise_cyc), 3);
    check("single_din_hold", 32'(bus.spi_din), 32'hA5C);
    tick(6);
    check("single_busy_fall", 32'(busy_fall_cyc - done_cyc), 3);
    cs_fall_dly = 5;
    cs_len      = 20;

    // Withdrawal: req[2] pulsed while busy with requester 0.
    bus.req_data[0 +: DW] = 12'h3C3;
    bus.req_data[2*DW +: DW] = 12'h7E7;
    exp_gnt.push_back('{0, 12'h3C3});
    exp_done.push_back(0);
    base  = n_gnt;
    dbase = n_done;
    bus.req = 4'b0001;
    wait_for(0, base + 1, 10, "wd_gnt_seen");
    bus.req = '0;
    tick(12);
    check("withdraw_busy_during", 32'(bus.busy), 1);
    bus.req = 4'b0100;
    tick(1);
    bus.req = '0;
    wait_for(1, dbase + 1, 100, "withdraw_done_seen");
    tick(20);
    check("withdraw_idle_busy", 32'(bus.busy), 0);
    check("withdraw_no_grant", 32'(n_gnt), 32'(base + 1));

    // Reset during XFER, then rotation restarts from requester 0.
    bus.req_data[0 +: DW] = 12'h777;
    exp_gnt.push_back('{0, 12'h777});
    exp_done.push_back(0);
    base = n_gnt;
    bus.req = 4'b0001;
    wait_for(0, base + 1, 10, "rstx_gnt_seen");
    bus.req = '0;
    tick(12);
    #2 rst = 1'b0;
    #1;
    check("rstx_gnt",  32'(bus.gnt), 0);
    check("rstx_done", 32'(bus.done), 0);
    check("rstx_err",  32'(bus.err), 0);
    check("rstx_busy", 32'(bus.busy), 0);
    check("rstx_newd", 32'(bus.spi_newd), 0);
    check("rstx_din",  32'(bus.spi_din), 0);
    exp_done = {};
    tick(3);
    rst = 1'b1;
    tick(4);
    bus.req_data[0 +: DW]    = 12'h0A1;
    bus.req_data[3*DW +: DW] = 12'h3A3;
    exp_gnt.push_back('{0, 12'h0A1});
    exp_gnt.push_back('{3, 12'h3A3});
    exp_done.push_back(0);
    exp_done.push_back(3);
    base  = n_gnt;
    dbase = n_done;
    bus.req = 4'b1001;
    wait_for(0, base + 1, 10, "post_rst_gnt0");
    bus.req = 4'b1000;
    wait_for(0, base + 2, 100, "post_rst_gnt3");
    bus.req = '0;
    wait_for(1, dbase + 2, 100, "post_rst_dones");
    tick(8);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: master never asserts cs.
    cs_en = 1'b0;
    bus.req_data[1*DW +: DW] = 12'h5B5;
    exp_gnt.push_back('{1, 12'h5B5});
    base = n_gnt;
    bus.req = 4'b0010;
    wait_for(0, base + 1, 10, "wdog_gnt_seen");
    bus.req = '0;
    gbase = gnt_cyc;
    wait_for(2, 1, 100, "wdog_err_seen");
    check("wdog_err_cycle", 32'(err_cyc - gbase), 64);
    check("wdog_newd_fall", 32'(newd_fall_cyc), 32'(err_cyc));
    cs_en = 1'b1;
    bus.req_data[2*DW +: DW] = 12'h2C2;
    exp_gnt.push_back('{2, 12'h2C2});
    exp_done.push_back(2);
    base  = n_gnt;
    dbase = n_done;
    bus.req = 4'b0100;
    wait_for(0, base + 1, 20, "wdog_next_gnt");
    bus.req = '0;
    check("wdog_regrant_spacing", 32'(gnt_cyc - err_cyc), 4);
    wait_for(1, dbase + 1, 100, "wdog_next_done");
    tick(8);
`else
    check("err_never_pulsed", 32'(n_err), 0);
`endif

    // GAP_CYCLES=0 instance with req[1] held back-to-back.
    bus0.req_data[1*DW +: DW] = 12'h0F1;
    bus0.req = 4'b0010;
    wait_for(3, 1, 10, "gap0_first_gnt");
    wait_for(4, 1, 100, "gap0_first_done");
    gbase = done0_cyc;
    wait_for(3, 2, 20, "gap0_second_gnt");
    bus0.req = '0;
    check("gap0_regrant_spacing", 32'(gnt0_cyc - gbase), 2);
    wait_for(4, 2, 100, "gap0_second_done");
    tick(5);

    check("exp_gnt_drained",  32'(exp_gnt.size()), 0);
    check("exp_done_drained", 32'(exp_done.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
